// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - program-run monitor: end-address, self-loop and timeout termination with run counters
module run_monitor #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned END_ADDR   = 32'h0000_5000,
    parameter int unsigned TIMEOUT    = 10000,
    parameter int unsigned LOOP_LIMIT = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pc_valid,
    input  logic             stall,
    input  logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [PC_W-1:0]  last_pc
);

    localparam int unsigned LOOP_W = $clog2(LOOP_LIMIT + 1);

    // Encoding chosen so running/done come straight off state flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_END     = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_LOOP    = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [PC_W-1:0]   last_pc_q, last_pc_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic              have_pc_q, have_pc_d;

    logic              accept;
    logic              end_hit;
    logic              repeat_hit;
    logic              loop_hit;
    logic              timeout_hit;
    logic [PC_W:0]     pc_plus4;

    // One extra bit so a PC near all-ones still compares as past the end.
    assign pc_plus4    = {1'b0, pc} + (PC_W + 1)'(4);
    assign accept      = (state_q == RUN) && pc_valid && !stall;
    assign end_hit     = accept && (pc_plus4 >= (PC_W + 1)'(END_ADDR));
    assign repeat_hit  = accept && have_pc_q && (pc == last_pc_q);
    assign loop_hit    = repeat_hit && (loop_q == LOOP_W'(LOOP_LIMIT - 1));
    assign timeout_hit = (state_q == RUN) && (cycle_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        last_pc_d = last_pc_q;
        loop_d    = loop_q;
        have_pc_d = have_pc_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cause_d   = CAUSE_NONE;
                    cycle_d   = '0;
                    instr_d   = '0;
                    last_pc_d = '0;
                    loop_d    = '0;
                    have_pc_d = 1'b0;
                end
            end
            RUN: begin
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
                if (accept) begin
                    instr_d   = instr_q + CNT_W'(1);
                    last_pc_d = pc;
                    have_pc_d = 1'b1;
                    loop_d    = repeat_hit ? loop_q + LOOP_W'(1) : '0;
                end
                if (end_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_END;
                end else if (loop_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_LOOP;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cause_q   <= CAUSE_NONE;
            cycle_q   <= '0;
            instr_q   <= '0;
            last_pc_q <= '0;
            loop_q    <= '0;
            have_pc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            last_pc_q <= last_pc_d;
            loop_q    <= loop_d;
            have_pc_q <= have_pc_d;
        end
    end

    assign running   = state_q[0];
    assign done      = state_q[1];
    assign cause     = cause_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
    assign last_pc   = last_pc_q;

endmodule
